// File: rtl/rvfi_arch_shadow_if.sv
// rvfi_arch_shadow_if: retired-step handshake from the insn model into the shadow state.
interface rvfi_arch_shadow_if #(parameter int XLEN = 32);
    logic            step_valid;
    logic            step_ready;
    logic            step_trap;
    logic [4:0]      step_rd_addr;
    logic [XLEN-1:0] step_rd_wdata;
    logic [XLEN-1:0] step_pc_wdata;

    modport master (
        output step_valid, step_trap, step_rd_addr, step_rd_wdata, step_pc_wdata,
        input  step_ready
    );

    modport slave (
        input  step_valid, step_trap, step_rd_addr, step_rd_wdata, step_pc_wdata,
        output step_ready
    );
endinterface

// File: rtl/rvfi_arch_shadow.sv
// rvfi_arch_shadow: shadow x1..x31/pc that chains retired steps into the next check's pre-state.
module rvfi_arch_shadow #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_PC  = '0,
    parameter int              CNT_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 restart,
    input  logic                 start,
    input  logic                 init_we,
    input  logic [4:0]           init_addr,
    input  logic [XLEN-1:0]      init_data,
    rvfi_arch_shadow_if.slave    step,
    input  logic [4:0]           rs1_addr,
    output logic [XLEN-1:0]      rs1_rdata,
    input  logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs2_rdata,
    output logic [XLEN-1:0]      pc,
    output logic [31*XLEN-1:0]   x_flat,
    output logic                 state_valid,
    output logic                 trapped,
    output logic                 misaligned,
    output logic [CNT_W-1:0]     retire_count
);
    typedef enum logic [1:0] {LOAD, RUN, TRAPPED} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] gpr [32];
    logic [XLEN-1:0] pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic            mis_q;
    logic            accept;
    logic            pc_bad;

    assign step.step_ready = (state == RUN) && !restart;
    assign accept          = step.step_valid && step.step_ready;
    assign pc_bad          = step.step_pc_wdata[1:0] != 2'b00;

    always_ff @(posedge clock) begin
        state <= reset ? LOAD : state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = restart          ? LOAD :
                   state == LOAD    ? (start ? RUN : LOAD) :
                   state == RUN     ? ((accept && (step.step_trap || pc_bad)) ? TRAPPED : RUN) :
                                      TRAPPED;
    end

    // gpr[0] is cleared on reset and never written, so x0 stays zero by construction
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            mis_q <= 1'b0;
        end else if (state == LOAD && init_we) begin
            if (init_addr == 5'd0) pc_q <= init_data;
            else gpr[init_addr] <= init_data;
        end else if (accept) begin
            if (step.step_trap) begin
                pc_q <= TRAP_PC;
            end else if (pc_bad) begin
                mis_q <= 1'b1;
            end else begin
                if (step.step_rd_addr != 5'd0) gpr[step.step_rd_addr] <= step.step_rd_wdata;
                pc_q  <= step.step_pc_wdata;
                cnt_q <= &cnt_q ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    assign rs1_rdata    = (rs1_addr == 5'd0) ? '0 : gpr[rs1_addr];
    assign rs2_rdata    = (rs2_addr == 5'd0) ? '0 : gpr[rs2_addr];
    assign pc           = pc_q;
    assign state_valid  = state == RUN;
    assign trapped      = state == TRAPPED;
    assign misaligned   = mis_q;
    assign retire_count = cnt_q;

    for (genvar g = 1; g < 32; g++) begin : g_flat
        assign x_flat[(g-1)*XLEN +: XLEN] = gpr[g];
    end
endmodule

// File: tb/tb_rvfi_arch_shadow.sv
// tb_rvfi_arch_shadow: scoreboard bench; a reference model pushes post-step state, compared a cycle later.
module tb_rvfi_arch_shadow;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, restart, start, init_we;
    logic [4:0]   init_addr, rs1_addr, rs2_addr;
    logic [31:0]  init_data, rs1_rdata, rs2_rdata, pc;
    logic [991:0] x_flat;
    logic         state_valid, trapped, misaligned;
    logic [15:0]  retire_count;

    logic         restart2, start2, init_we2;
    logic [4:0]   init_addr2, rs1_addr2, rs2_addr2;
    logic [31:0]  init_data2, rs1_rdata2, rs2_rdata2, pc2;
    logic [991:0] x_flat2;
    logic         state_valid2, trapped2, misaligned2;
    logic [1:0]   retire_count2;

    rvfi_arch_shadow_if #(.XLEN(32)) sif ();
    rvfi_arch_shadow_if #(.XLEN(32)) sif2 ();

    rvfi_arch_shadow #(.XLEN(32), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .restart(restart), .start(start),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .step(sif.slave),
        .rs1_addr(rs1_addr), .rs1_rdata(rs1_rdata), .rs2_addr(rs2_addr), .rs2_rdata(rs2_rdata),
        .pc(pc), .x_flat(x_flat), .state_valid(state_valid), .trapped(trapped),
        .misaligned(misaligned), .retire_count(retire_count)
    );

    rvfi_arch_shadow #(.XLEN(32), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .restart(restart2), .start(start2),
        .init_we(init_we2), .init_addr(init_addr2), .init_data(init_data2),
        .step(sif2.slave),
        .rs1_addr(rs1_addr2), .rs1_rdata(rs1_rdata2), .rs2_addr(rs2_addr2), .rs2_rdata(rs2_rdata2),
        .pc(pc2), .x_flat(x_flat2), .state_valid(state_valid2), .trapped(trapped2),
        .misaligned(misaligned2), .retire_count(retire_count2)
    );

    typedef struct packed {
        logic [31:0]  pc;
        logic [15:0]  cnt;
        logic         tr;
        logic         mis;
        logic         sv;
        logic [991:0] xf;
    } exp_t;

    exp_t        q[$];
    int          q2[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_x [32];
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic        m_mis;
    int          m_state;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        restart = 0; start = 0; init_we = 0; init_addr = 0; init_data = 0;
        sif.step_valid = 0; sif.step_trap = 0; sif.step_rd_addr = 0;
        sif.step_rd_wdata = 0; sif.step_pc_wdata = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = 0;
        m_pc = 0; m_cnt = 0; m_mis = 0; m_state = 0;
    endtask

    task automatic model_apply();
        if (restart) begin
            model_reset();
        end else if (m_state == 0) begin
            if (init_we) begin
                if (init_addr == 0) m_pc = init_data;
                else m_x[init_addr] = init_data;
            end
            if (start) m_state = 1;
        end else if (m_state == 1 && sif.step_valid) begin
            if (sif.step_trap) begin
                m_pc = 32'h0; m_state = 2;
            end else if (sif.step_pc_wdata[1:0] != 0) begin
                m_mis = 1; m_state = 2;
            end else begin
                if (sif.step_rd_addr != 0) m_x[sif.step_rd_addr] = sif.step_rd_wdata;
                m_pc = sif.step_pc_wdata;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic advance();
        exp_t e;
        model_apply();
        e.pc = m_pc; e.cnt = m_cnt; e.mis = m_mis;
        e.tr = m_state == 2; e.sv = m_state == 1;
        for (int i = 1; i < 32; i++) e.xf[(i-1)*32 +: 32] = m_x[i];
        q.push_back(e);
        @(posedge clock); #1;
        clear_inputs();
        @(negedge clock);
        if (q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            e = q.pop_front();
            check("pc", pc, e.pc);
            check("retire_count", retire_count, e.cnt);
            check("trapped", trapped, e.tr);
            check("misaligned", misaligned, e.mis);
            check("state_valid", state_valid, e.sv);
            for (int i = 1; i < 32; i++)
                check($sformatf("x%0d", i), x_flat[(i-1)*32 +: 32], e.xf[(i-1)*32 +: 32]);
        end
    endtask

    task automatic drive(input logic trap, input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] pcw);
        sif.step_valid = 1; sif.step_trap = trap; sif.step_rd_addr = rd;
        sif.step_rd_wdata = wd; sif.step_pc_wdata = pcw;
    endtask

    task automatic init(input logic [4:0] a, input logic [31:0] d);
        init_we = 1; init_addr = a; init_data = d;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rs1_addr = 0; rs2_addr = 0;
        restart2 = 0; start2 = 0; init_we2 = 0; init_addr2 = 0; init_data2 = 0;
        rs1_addr2 = 5'd1; rs2_addr2 = 0;
        sif2.step_valid = 0; sif2.step_trap = 0; sif2.step_rd_addr = 0;
        sif2.step_rd_wdata = 0; sif2.step_pc_wdata = 0;
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_ready", sif.step_ready, 0);
        check("rst_valid", state_valid, 0);
        check("rst_trapped", trapped, 0);
        check("rst_pc", pc, 0);
        check("rst_count", retire_count, 0);
        check("rst_mis", misaligned, 0);
        check("rst_count2", retire_count2, 0);

        init(5, 32'h1234); advance();
        init(3, 32'hDEADBEEF); advance();
        init(0, 32'h100); advance();
        rs1_addr = 5; #1;
        check("load_ready", sif.step_ready, 0);
        start = 1; advance();
        check("run_rs1_x5", rs1_rdata, 32'h1234);

        drive(0, 5, 32'hA, 32'h104); #1;
        check("acc_ready", sif.step_ready, 1);
        check("acc_x5_old", rs1_rdata, 32'h1234);
        check("acc_pc_old", pc, 32'h100);
        advance();
        check("post_x5", rs1_rdata, 32'hA);

        drive(0, 0, 32'hFFFF_FFFF, 32'h108); advance();
        rs1_addr = 0; #1;
        check("x0_read", rs1_rdata, 0);

        drive(0, 7, 32'h11, 32'h10C); advance();
        drive(0, 7, 32'h22, 32'h110); advance();
        rs2_addr = 7; #1;
        check("b2b_x7", rs2_rdata, 32'h22);

        drive(1, 3, 32'h55, 32'h200); advance();
        rs1_addr = 3; #1;
        check("trap_ready", sif.step_ready, 0);
        check("trap_x3", rs1_rdata, 32'hDEADBEEF);
        drive(0, 9, 32'h99, 32'h300); advance();
        drive(0, 9, 32'h99, 32'h300); advance();

        restart = 1; advance();
        init(0, 32'h40); advance();
        init(7, 32'h77); start = 1; advance();
        drive(0, 8, 32'h88, 32'h44); advance();
        drive(0, 7, 32'h1, 32'h102); advance();
        check("mis_x7", rs2_rdata, 32'h77);
        restart = 1; advance();
        check("restart_x7", rs2_rdata, 0);

        start2 = 1;
        @(posedge clock); #1 start2 = 0;
        for (int i = 0; i < 5; i++) begin
            sif2.step_valid = 1; sif2.step_rd_addr = 1;
            sif2.step_rd_wdata = i + 1; sif2.step_pc_wdata = (i + 1) * 4;
            q2.push_back(i + 1 > 3 ? 3 : i + 1);
            @(posedge clock); #1 sif2.step_valid = 0;
            @(negedge clock);
            if (q2.size() == 0) check("q2_empty", 1, 0);
            else check($sformatf("sat_count%0d", i), retire_count2, q2.pop_front());
        end
        check("sat_x1", rs1_rdata2, 5);
        check("sat_pc", pc2, 32'h14);
        sif2.step_valid = 1; sif2.step_rd_addr = 1; sif2.step_rd_wdata = 32'h99;
        sif2.step_pc_wdata = 32'h100; restart2 = 1; #1;
        check("restart_ready", sif2.step_ready, 0);
        @(posedge clock); #1 sif2.step_valid = 0; restart2 = 0;
        @(negedge clock);
        check("restart2_pc", pc2, 0);
        check("restart2_count", retire_count2, 0);
        check("restart2_valid", state_valid2, 0);
        check("restart2_x1", rs1_rdata2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
